// File: rtl/pcs_tx_idle_pkg.sv
// rtl/pcs_tx_idle_pkg.sv - XAUI PHY shared character constants, column classes and PRBS step
package pcs_tx_idle_pkg;

    // XGMII / 8b10b special characters
    localparam logic [7:0] CH_I = 8'h07;
    localparam logic [7:0] CH_S = 8'hFB;
    localparam logic [7:0] CH_T = 8'hFD;
    localparam logic [7:0] CH_E = 8'hFE;
    localparam logic [7:0] CH_Q = 8'h9C;
    localparam logic [7:0] CH_K = 8'hBC;
    localparam logic [7:0] CH_R = 8'h1C;
    localparam logic [7:0] CH_A = 8'h7C;

    // Class of the previously transmitted column; shared with the receive side
    typedef enum logic [1:0] {
        CLS_A       = 2'd0,
        CLS_T       = 2'd1,
        CLS_DATA    = 2'd2,
        CLS_IDLE_KR = 2'd3
    } col_class_t;

    localparam logic [6:0] PRBS_SEED = 7'h7F;

    // x^7 + x^6 + 1, shifting towards the MSB
    function automatic logic [6:0] prbs_next(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[5]};
    endfunction

endpackage

// File: rtl/pcs_tx_col.sv
// rtl/pcs_tx_col.sv - combinational encoder for one XGMII column
//
// Ports:
//   txd, txc        : four lanes of XGMII data and control flags (lane n = txd[8n+7:8n])
//   prbs_in         : idle PRBS state seen by this column
//   a_cnt_in        : ||A|| spacing counter seen by this column
//   cls_in          : class of the preceding column
//   enc, charisk    : encoded lane bytes and K flags
//   prbs_out, a_cnt_out, cls_out : state handed to the following column
module pcs_tx_col
    import pcs_tx_idle_pkg::*;
(
    input  logic [31:0] txd,
    input  logic [3:0]  txc,
    input  logic [6:0]  prbs_in,
    input  logic [4:0]  a_cnt_in,
    input  logic [1:0]  cls_in,
    output logic [31:0] enc,
    output logic [3:0]  charisk,
    output logic [6:0]  prbs_out,
    output logic [4:0]  a_cnt_out,
    output logic [1:0]  cls_out
);

    logic       is_idle;
    logic       has_t;
    logic       seen_t;
    logic [7:0] b;
    logic [7:0] code;

    always_comb begin
        is_idle   = 1'b1;
        has_t     = 1'b0;
        seen_t    = 1'b0;
        b         = 8'h00;
        code      = CH_K;
        enc       = 32'h0;
        charisk   = 4'h0;
        prbs_out  = prbs_next(prbs_in);
        a_cnt_out = (a_cnt_in == 5'd0) ? 5'd0 : a_cnt_in - 5'd1;
        cls_out   = CLS_DATA;

        for (int i = 0; i < 4; i++) begin
            b = txd[8*i +: 8];
            if (!(txc[i] && b == CH_I)) is_idle = 1'b0;
            if (txc[i] && b == CH_T)    has_t   = 1'b1;
        end

        if (is_idle) begin
            // ||A|| priority; never two in a row since cls_in carries across the cycle boundary
            if (a_cnt_in == 5'd0 && cls_in != CLS_A) begin
                code      = CH_A;
                a_cnt_out = {1'b1, prbs_in[3:0]};
                cls_out   = CLS_A;
            end else if (cls_in == CLS_T || cls_in == CLS_DATA) begin
                code    = CH_K;
                cls_out = CLS_IDLE_KR;
            end else begin
                code    = prbs_in[0] ? CH_R : CH_K;
                cls_out = CLS_IDLE_KR;
            end
            enc     = {4{code}};
            charisk = 4'hF;
        end else begin
            cls_out = has_t ? CLS_T : CLS_DATA;
            for (int i = 0; i < 4; i++) begin
                b = txd[8*i +: 8];
                if (!txc[i]) begin
                    enc[8*i +: 8] = b;
                    charisk[i]    = 1'b0;
                end else if (b == CH_T) begin
                    enc[8*i +: 8] = b;
                    charisk[i]    = 1'b1;
                    seen_t        = 1'b1;
                end else if (b == CH_S || b == CH_E || b == CH_Q) begin
                    enc[8*i +: 8] = b;
                    charisk[i]    = 1'b1;
                end else if (b == CH_I && seen_t) begin
                    // idle trailing a terminate becomes /K/
                    enc[8*i +: 8] = CH_K;
                    charisk[i]    = 1'b1;
                end else begin
                    enc[8*i +: 8] = CH_E;
                    charisk[i]    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pcs_tx_idle.sv
// rtl/pcs_tx_idle.sv - XGMII to 8b10b-encoder transmit idle/control translation, two columns per clk
//
// Ports:
//   clk        : transmit clock
//   reset      : asynchronous active-high reset
//   xgmii_txd  : 64-bit XGMII data, column 0 in [31:0], column 1 in [63:32]
//   xgmii_txc  : XGMII control flags, bit 4c+n for lane n of column c
//   txdata     : encoder data, lane n in [16n+15:16n], column 0 in the low byte
//   txcharisk  : K flags, bit 2n+c for lane n of column c
module pcs_tx_idle
    import pcs_tx_idle_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] xgmii_txd,
    input  logic [7:0]  xgmii_txc,
    output logic [63:0] txdata,
    output logic [7:0]  txcharisk
);

    logic [6:0]  prbs_q;
    logic [4:0]  a_cnt_q;
    logic [1:0]  cls_q;

    logic [31:0] enc0, enc1;
    logic [3:0]  k0, k1;
    logic [6:0]  prbs0, prbs1;
    logic [4:0]  a_cnt0, a_cnt1;
    logic [1:0]  cls0, cls1;
    logic [63:0] txdata_d;
    logic [7:0]  txcharisk_d;

    pcs_tx_col u_col0 (
        .txd       (xgmii_txd[31:0]),
        .txc       (xgmii_txc[3:0]),
        .prbs_in   (prbs_q),
        .a_cnt_in  (a_cnt_q),
        .cls_in    (cls_q),
        .enc       (enc0),
        .charisk   (k0),
        .prbs_out  (prbs0),
        .a_cnt_out (a_cnt0),
        .cls_out   (cls0)
    );

    // Column 1 sees column 0's updated state within the same cycle
    pcs_tx_col u_col1 (
        .txd       (xgmii_txd[63:32]),
        .txc       (xgmii_txc[7:4]),
        .prbs_in   (prbs0),
        .a_cnt_in  (a_cnt0),
        .cls_in    (cls0),
        .enc       (enc1),
        .charisk   (k1),
        .prbs_out  (prbs1),
        .a_cnt_out (a_cnt1),
        .cls_out   (cls1)
    );

    always_comb begin
        txdata_d    = 64'h0;
        txcharisk_d = 8'h0;
        for (int n = 0; n < 4; n++) begin
            txdata_d[16*n +: 16]  = {enc1[8*n +: 8], enc0[8*n +: 8]};
            txcharisk_d[2*n]      = k0[n];
            txcharisk_d[2*n + 1]  = k1[n];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prbs_q    <= PRBS_SEED;
            a_cnt_q   <= 5'd0;
            cls_q     <= CLS_IDLE_KR;
            txdata    <= {8{CH_K}};
            txcharisk <= 8'hFF;
        end else begin
            prbs_q    <= prbs1;
            a_cnt_q   <= a_cnt1;
            cls_q     <= cls1;
            txdata    <= txdata_d;
            txcharisk <= txcharisk_d;
        end
    end

endmodule

// File: tb/tb_pcs_tx_idle.sv
// tb/tb_pcs_tx_idle.sv - self-checking bench for pcs_tx_idle with a column-level reference model
module tb_pcs_tx_idle;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic [63:0] txdata;
    logic [7:0]  txcharisk;

    pcs_tx_idle dut (
        .clk       (clk),
        .reset     (reset),
        .xgmii_txd (xgmii_txd),
        .xgmii_txc (xgmii_txc),
        .txdata    (txdata),
        .txcharisk (txcharisk)
    );

    always #5 clk = ~clk;

    localparam int PA = 0, PT = 1, PD = 2, PKR = 3;
    localparam logic [63:0] IDLE_D = 64'h0707070707070707;

    int checks = 0;
    int failures = 0;

    // reference state
    logic [6:0] prbs_seq [127];
    int m_pidx, m_acnt, m_prev;
    int col_idx, last_a, a_count;
    int a_gaps [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pidx = 0;
        m_acnt = 0;
        m_prev = PKR;
        last_a = -1;
    endtask

    function automatic bit is_ctl_pass(input logic [7:0] v);
        return v == 8'hFB || v == 8'hFD || v == 8'hFE || v == 8'h9C;
    endfunction

    task automatic model_col(input logic [31:0] d, input logic [3:0] c,
                             output logic [31:0] e, output logic [3:0] k);
        logic [6:0] p;
        logic [7:0] code;
        int tpos;
        p = prbs_seq[m_pidx];
        m_pidx = (m_pidx + 1) % 127;
        e = '0;
        k = '0;
        if (c == 4'hF && d == 32'h07070707) begin
            if (m_acnt == 0 && m_prev != PA) begin
                code   = 8'h7C;
                m_acnt = 16 + int'(p[3:0]);
                m_prev = PA;
            end else begin
                if (m_prev == PT || m_prev == PD) code = 8'hBC;
                else                               code = p[0] ? 8'h1C : 8'hBC;
                m_acnt = (m_acnt > 0) ? m_acnt - 1 : 0;
                m_prev = PKR;
            end
            e = {code, code, code, code};
            k = 4'hF;
        end else begin
            tpos = 4;
            for (int i = 3; i >= 0; i--)
                if (c[i] && d[8*i +: 8] == 8'hFD) tpos = i;
            for (int i = 0; i < 4; i++) begin
                if (!c[i]) begin
                    e[8*i +: 8] = d[8*i +: 8];
                end else begin
                    k[i] = 1'b1;
                    if (is_ctl_pass(d[8*i +: 8]))                e[8*i +: 8] = d[8*i +: 8];
                    else if (d[8*i +: 8] == 8'h07 && i > tpos)   e[8*i +: 8] = 8'hBC;
                    else                                         e[8*i +: 8] = 8'hFE;
                end
            end
            m_acnt = (m_acnt > 0) ? m_acnt - 1 : 0;
            m_prev = (tpos < 4) ? PT : PD;
        end
    endtask

    // Drive one cycle, predict, then compare one clk later
    task automatic step(input logic [63:0] d, input logic [7:0] c);
        logic [31:0] e0, e1;
        logic [3:0]  k0, k1;
        logic [63:0] ed;
        logic [7:0]  ek;
        logic [31:0] ocol;
        xgmii_txd = d;
        xgmii_txc = c;
        model_col(d[31:0], c[3:0], e0, k0);
        model_col(d[63:32], c[7:4], e1, k1);
        for (int n = 0; n < 4; n++) begin
            ed[16*n +: 16] = {e1[8*n +: 8], e0[8*n +: 8]};
            ek[2*n]        = k0[n];
            ek[2*n + 1]    = k1[n];
        end
        @(posedge clk);
        #1;
        check("txdata", txdata, ed);
        check("txcharisk", {56'h0, txcharisk}, {56'h0, ek});
        for (int cc = 0; cc < 2; cc++) begin
            for (int n = 0; n < 4; n++) ocol[8*n +: 8] = txdata[16*n + 8*cc +: 8];
            if (ocol == 32'h7C7C7C7C) begin
                a_count++;
                if (last_a >= 0) begin
                    a_gaps.push_back(col_idx - last_a);
                    check("a_not_adjacent", 64'(col_idx - last_a >= 2), 64'd1);
                end
                last_a = col_idx;
            end
            col_idx++;
        end
    endtask

    task automatic rand_col(output logic [31:0] d, output logic [3:0] c);
        int kind, tpos;
        logic [7:0] pool [6];
        pool[0] = 8'hFB; pool[1] = 8'hFE; pool[2] = 8'h9C;
        pool[3] = 8'h07; pool[4] = 8'h55; pool[5] = 8'hBC;
        kind = $urandom_range(0, 4);
        d = $urandom;
        c = 4'h0;
        case (kind)
            0: begin d = 32'h07070707; c = 4'hF; end
            1: ;
            2: begin
                tpos = $urandom_range(0, 3);
                for (int i = 0; i < 4; i++) begin
                    if (i == tpos)     begin d[8*i +: 8] = 8'hFD; c[i] = 1'b1; end
                    else if (i > tpos) begin d[8*i +: 8] = 8'h07; c[i] = 1'b1; end
                end
            end
            3: begin
                c = 4'($urandom);
                for (int i = 0; i < 4; i++)
                    if (c[i]) d[8*i +: 8] = pool[$urandom_range(0, 5)];
            end
            default: begin d[7:0] = 8'hFB; c = 4'h1; end
        endcase
    endtask

    initial begin
        logic [6:0]  s;
        logic [31:0] rd0, rd1;
        logic [3:0]  rc0, rc1;
        int budget, seen;

        s = 7'h7F;
        for (int i = 0; i < 127; i++) begin
            prbs_seq[i] = s;
            s = {s[5:0], s[6] ^ s[5]};
        end
        col_idx = 0;
        a_count = 0;

        // reset state
        reset = 1'b1;
        xgmii_txd = IDLE_D;
        xgmii_txc = 8'hFF;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_txdata", txdata, 64'hBCBC_BCBC_BCBC_BCBC);
        check("reset_txcharisk", {56'h0, txcharisk}, 64'hFF);
        reset = 1'b0;

        // first idle cycle: ||A|| then ||K||
        step(IDLE_D, 8'hFF);
        check("first_idle_AK", txdata, 64'hBC7C_BC7C_BC7C_BC7C);

        // continuous idle
        a_gaps.delete();
        a_count = 1;
        for (int i = 0; i < 80; i++) step(IDLE_D, 8'hFF);
        check("idle_a_count_min", 64'(a_count >= 5), 64'd1);
        foreach (a_gaps[i])
            check("idle_a_gap_range", 64'(a_gaps[i] >= 17 && a_gaps[i] <= 32), 64'd1);

        // frame passthrough
        step({32'h11223344, 32'h555555FB}, 8'h01);
        check("frame_txdata", txdata, 64'h1155_2255_3355_44FB);
        check("frame_charisk", {56'h0, txcharisk}, 64'h01);

        // terminate column followed by an idle column
        step({32'h07070707, 32'h0707FDAA}, 8'hFE);
        check("term_col0_bytes", {32'h0, txdata[55:48], txdata[39:32], txdata[23:16], txdata[7:0]},
              64'hBCBC_FDAA);
        check("term_col0_k", {60'h0, txcharisk[6], txcharisk[4], txcharisk[2], txcharisk[0]}, 64'hE);

        // invalid control on lane 2
        step({32'h99887766, 32'h40552010}, 8'h04);
        check("invalid_col0_bytes", {32'h0, txdata[55:48], txdata[39:32], txdata[23:16], txdata[7:0]},
              64'h40FE_2010);
        check("invalid_charisk", {56'h0, txcharisk}, 64'h10);

        // randomized traffic
        for (int i = 0; i < 150; i++) begin
            rand_col(rd0, rc0);
            rand_col(rd1, rc1);
            step({rd1, rd0}, {rc1, rc0});
        end

        // mid-frame async reset, between edges
        step({32'h11223344, 32'h555555FB}, 8'h01);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_txdata", txdata, 64'hBCBC_BCBC_BCBC_BCBC);
        check("async_reset_charisk", {56'h0, txcharisk}, 64'hFF);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        step(IDLE_D, 8'hFF);
        check("post_reset_AK", txdata, 64'hBC7C_BC7C_BC7C_BC7C);
        for (int i = 0; i < 10; i++) step(IDLE_D, 8'hFF);

        // a_cnt reaches 0 on column 1 while the next column 0 is idle
        budget = 0;
        while (m_acnt != 2 && budget < 40) begin
            step(IDLE_D, 8'hFF);
            budget++;
        end
        check("boundary_reached", 64'(m_acnt == 2), 64'd1);
        seen = a_count;
        step(IDLE_D, 8'hFF);
        check("boundary_no_A_yet", 64'(a_count - seen), 64'd0);
        step(IDLE_D, 8'hFF);
        check("boundary_one_A", 64'(a_count - seen), 64'd1);
        check("boundary_A_on_col0", {48'h0, txdata[7:0], txdata[15:8]} , {48'h0, 8'h7C, (txdata[15:8] == 8'h7C) ? 8'h00 : txdata[15:8]});
        for (int i = 0; i < 5; i++) step(IDLE_D, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
